// File: rtl/contador_pulsos_bcd.sv
// Up/down pulse counter with clamped switch load, wrap flag and a registered
// two-digit active-low 7-segment display of the count.
module contador_pulsos_bcd #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_pulse,
  input  logic             dec_pulse,
  input  logic             load_pulse,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             wrap_pulse,
  output logic [6:0]       seg_units,
  output logic [6:0]       seg_tens
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [6:0]       seg_units_q, seg_units_d;
  logic [6:0]       seg_tens_q, seg_tens_d;
  logic [31:0]      count_ext;
  logic [3:0]       tens, units;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load_pulse) begin
      count_d = (load_value > MAX_C) ? MAX_C : load_value;
    end else if (inc_pulse && !dec_pulse) begin
      if (count_q == MAX_C) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (dec_pulse && !inc_pulse) begin
      if (count_q == '0) begin
        count_d = MAX_C;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // Display decodes the already-registered count, so segments trail count by one cycle.
  always_comb begin
    count_ext   = 32'(count_q);
    tens        = 4'(count_ext / 32'd10);
    units       = 4'(count_ext % 32'd10);
    seg_units_d = seg7(units);
    seg_tens_d  = (tens == 4'd0) ? 7'b1111111 : seg7(tens);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      wrap_q      <= 1'b0;
      seg_units_q <= 7'b1000000;
      seg_tens_q  <= '1;
    end else begin
      count_q     <= count_d;
      wrap_q      <= wrap_d;
      seg_units_q <= seg_units_d;
      seg_tens_q  <= seg_tens_d;
    end
  end

  assign count      = count_q;
  assign wrap_pulse = wrap_q;
  assign seg_units  = seg_units_q;
  assign seg_tens   = seg_tens_q;

endmodule

// File: tb/tb_contador_pulsos_bcd.sv
// Bench for contador_pulsos_bcd: default (4-bit, max 15) and a 5-bit, max 20
// instance driven in lockstep and compared against an arithmetic model.
module tb_contador_pulsos_bcd;

  logic       clk = 1'b0;
  logic       reset_s, inc_s, dec_s, load_s;
  logic [4:0] lv_s;
  logic [3:0] count_a;
  logic [4:0] count_b;
  logic       wrap_a, wrap_b;
  logic [6:0] su_a, st_a, su_b, st_b;

  int vectors     = 0;
  int miscompares = 0;
  int mc[2];
  int mw[2];
  int maxv[2]  = '{15, 20};
  int modv[2]  = '{16, 32};

  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};

  always #5 clk = ~clk;

  contador_pulsos_bcd dut_a (
    .clk(clk), .reset(reset_s), .inc_pulse(inc_s), .dec_pulse(dec_s),
    .load_pulse(load_s), .load_value(lv_s[3:0]), .count(count_a),
    .wrap_pulse(wrap_a), .seg_units(su_a), .seg_tens(st_a)
  );

  contador_pulsos_bcd #(.WIDTH(5), .MAX_COUNT(20)) dut_b (
    .clk(clk), .reset(reset_s), .inc_pulse(inc_s), .dec_pulse(dec_s),
    .load_pulse(load_s), .load_value(lv_s), .count(count_b),
    .wrap_pulse(wrap_b), .seg_units(su_b), .seg_tens(st_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit ld, input int lv, input bit inc, input bit dec);
    int old, v;
    logic [6:0] esu[2], est[2];
    reset_s = rst; load_s = ld; lv_s = 5'(lv); inc_s = inc; dec_s = dec;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      old   = mc[k];
      mw[k] = 0;
      if (rst) mc[k] = 0;
      else if (ld) begin
        v = lv % modv[k];
        mc[k] = (v > maxv[k]) ? maxv[k] : v;
      end else if (inc && !dec) begin
        if (mc[k] == maxv[k]) begin mc[k] = 0; mw[k] = 1; end
        else mc[k] = mc[k] + 1;
      end else if (dec && !inc) begin
        if (mc[k] == 0) begin mc[k] = maxv[k]; mw[k] = 1; end
        else mc[k] = mc[k] - 1;
      end
      esu[k] = rst ? 7'b1000000 : SEG[old % 10];
      est[k] = (rst || old / 10 == 0) ? 7'b1111111 : SEG[old / 10];
    end
    check("a_count", 32'(count_a), mc[0]);
    check("a_wrap", 32'(wrap_a), mw[0]);
    check("a_seg_units", 32'(su_a), 32'(esu[0]));
    check("a_seg_tens", 32'(st_a), 32'(est[0]));
    check("b_count", 32'(count_b), mc[1]);
    check("b_wrap", 32'(wrap_b), mw[1]);
    check("b_seg_units", 32'(su_b), 32'(esu[1]));
    check("b_seg_tens", 32'(st_b), 32'(est[1]));
  endtask

  initial begin
    mc = '{0, 0};
    mw = '{0, 0};
    reset_s = 1'b1; inc_s = 1'b0; dec_s = 1'b0; load_s = 1'b0; lv_s = '0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // three isolated increments
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
    end
    check("a_count_is_3", 32'(count_a), 3);
    check("a_seg_units_3", 32'(su_a), 32'(7'b0110000));
    // load 14, wrap upward
    step(0, 1, 14, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // wrap downward from 0
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("a_seg_tens_15", 32'(st_a), 32'(7'b1111001));
    check("a_seg_units_15", 32'(su_a), 32'(7'b0010010));
    // simultaneous inc/dec hold, load priority over inc
    step(0, 1, 7, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 1, 9, 1, 0);
    step(0, 0, 0, 0, 0);
    // load clamp: 15 on A, 25 clamps to 20 on B (A sees 9)
    step(0, 1, 15, 0, 0);
    step(0, 1, 25, 0, 0);
    step(0, 0, 0, 0, 0);
    check("b_clamp_20", 32'(count_b), 20);
    check("b_seg_tens_2", 32'(st_b), 32'(7'b0100100));
    // reset overrides a simultaneous increment
    step(0, 1, 12, 0, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
